// File: rtl/output_controller.sv
// Queues 4-bit output patterns from the CPU and shows each one on leds_out for HOLD_CYCLES cycles.
// Define OUTPUT_CTRL_OVF_EN to add the sticky overflow output for dropped writes.
module output_controller #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned HOLD_CYCLES  = 1_000_000,
    parameter logic [3:0]  IDLE_PATTERN = 4'b0000
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       cpu_write_en,
    input  logic [3:0] data_from_cpu,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       busy,
    output logic [3:0] leds_out
`ifdef OUTPUT_CTRL_OVF_EN
    ,
    output logic       overflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          wr_accept;
    logic          pop;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]    leds_d;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign wr_accept  = cpu_write_en && !fifo_full;
    assign busy       = (state_q == StHold);

    always_ff @(posedge sys_clock) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= data_from_cpu;
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)       rd_ptr_q <= rd_ptr_q + AW'(1);
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({wr_accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            leds_out   <= IDLE_PATTERN;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            leds_out   <= leds_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        leds_d     = leds_out;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    leds_d     = mem[rd_ptr_q];
                    hold_cnt_d = HOLD_INIT;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end else if (!fifo_empty) begin
                    // Chain straight into the next entry with no idle gap.
                    pop        = 1'b1;
                    leds_d     = mem[rd_ptr_q];
                    hold_cnt_d = HOLD_INIT;
                end else begin
                    leds_d  = IDLE_PATTERN;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef OUTPUT_CTRL_OVF_EN
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (cpu_write_en && fifo_full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_output_controller.sv
// Bench for output_controller: directed steps plus random writes checked against a queue-based
// display model; a second instance covers HOLD_CYCLES=1 with a non-zero idle pattern.
module tb_output_controller;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 4;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       cpu_write_en  = 1'b0;
    logic [3:0] data_from_cpu = 4'h0;
    logic       fifo_full, fifo_empty, busy, overflow;
    logic [3:0] leds_out;

    logic       we1 = 1'b0;
    logic [3:0] d1  = 4'h0;
    logic       full1, empty1, busy1, ovf1;
    logic [3:0] leds1;

    int tests = 0;
    int fails = 0;

    always #5 sys_clock = ~sys_clock;

    output_controller #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .IDLE_PATTERN(4'b0000)) dut (
        .sys_clock     (sys_clock),
        .reset         (reset),
        .cpu_write_en  (cpu_write_en),
        .data_from_cpu (data_from_cpu),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .busy          (busy),
        .leds_out      (leds_out)
`ifdef OUTPUT_CTRL_OVF_EN
        ,
        .overflow      (overflow)
`endif
    );

    output_controller #(.DEPTH(4), .HOLD_CYCLES(1), .IDLE_PATTERN(4'b0101)) dut1 (
        .sys_clock     (sys_clock),
        .reset         (reset),
        .cpu_write_en  (we1),
        .data_from_cpu (d1),
        .fifo_full     (full1),
        .fifo_empty    (empty1),
        .busy          (busy1),
        .leds_out      (leds1)
`ifdef OUTPUT_CTRL_OVF_EN
        ,
        .overflow      (ovf1)
`endif
    );

`ifndef OUTPUT_CTRL_OVF_EN
    assign overflow = 1'b0;
    assign ovf1     = 1'b0;
`endif

    // Reference model: queued entries, the pattern on display and how many cycles it has left.
    int   q[$];
    bit   showing;
    int   shown;
    int   left;
    bit   m_ovf;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        showing = 0;
        shown   = 0;
        left    = 0;
        m_ovf   = 0;
    endtask

    task automatic model_edge(input bit we, input int d);
        bit was_full  = (q.size() == DEPTH);
        bit was_empty = (q.size() == 0);
        if (showing && left > 1) begin
            left--;
        end else if (!was_empty) begin
            shown   = q.pop_front();
            left    = HOLD;
            showing = 1;
        end else begin
            showing = 0;
        end
        if (we && !was_full) q.push_back(d);
        else if (we)         m_ovf = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".leds"},  leds_out,   showing ? shown[3:0] : 4'h0);
        chk({tag, ".busy"},  busy,       showing);
        chk({tag, ".empty"}, fifo_empty, q.size() == 0);
        chk({tag, ".full"},  fifo_full,  q.size() == DEPTH);
`ifdef OUTPUT_CTRL_OVF_EN
        chk({tag, ".ovf"},   overflow,   m_ovf);
`endif
    endtask

    task automatic step(input string tag, input bit we, input logic [3:0] d);
        cpu_write_en  = we;
        data_from_cpu = d;
        @(posedge sys_clock);
        model_edge(we, d);
        #1;
        cpu_write_en = 1'b0;
        check_model(tag);
    endtask

    task automatic step1(input bit we, input logic [3:0] d, input logic [3:0] e_leds,
                         input bit e_busy, input bit e_empty);
        we1 = we;
        d1  = d;
        @(posedge sys_clock);
        #1;
        we1 = 1'b0;
        chk("h1.leds",  leds1,  e_leds);
        chk("h1.busy",  busy1,  e_busy);
        chk("h1.empty", empty1, e_empty);
        chk("h1.full",  full1,  1'b0);
    endtask

    initial begin
        int shown_a;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge sys_clock);
        #1;
        chk("rst.leds", leds_out, 4'h0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.empty", fifo_empty, 1'b1);
        chk("rst.full", fifo_full, 1'b0);
        chk("rst.leds1", leds1, 4'h5);
        #4 reset = 1'b0;

        // Single write: one cycle of latency, then exactly HOLD cycles of 1010.
        step("sw0", 1'b1, 4'hA);
        chk("sw.lat_leds", leds_out, 4'h0);
        chk("sw.lat_empty", fifo_empty, 1'b0);
        shown_a = 0;
        for (int i = 0; i < 7; i++) begin
            step("sw", 1'b0, 4'h0);
            if (leds_out == 4'hA && busy) shown_a++;
        end
        chk("sw.hold_len", 8'(shown_a), 8'(HOLD));
        chk("sw.back_idle", leds_out, 4'h0);

        // Burst of three back-to-back writes.
        for (int i = 1; i <= 3; i++) step("burst_w", 1'b1, 4'(i));
        for (int i = 0; i < 14; i++) step("burst", 1'b0, 4'h0);

        // Continuous writes overfill the FIFO, hitting drops with and without a pop.
        for (int i = 0; i < 12; i++) step("fill", 1'b1, 4'($urandom_range(0, 15)));
        chk("fill.full_seen", fifo_full, 1'b1);
        for (int i = 0; i < 22; i++) step("drain", 1'b0, 4'h0);

        // Random traffic at light and heavy write rates.
        for (int i = 0; i < 300; i++)
            step("rnd", $urandom_range(0, 99) < 30, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 150; i++)
            step("rndh", $urandom_range(0, 99) < 85, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 25; i++) step("rdrain", 1'b0, 4'h0);

        // Reset in the middle of a hold with three entries still queued.
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 4'(i + 7));
        step("pre_rst", 1'b0, 4'h0);
        chk("pre_rst.busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("mrst.leds", leds_out, 4'h0);
        chk("mrst.busy", busy, 1'b0);
        chk("mrst.empty", fifo_empty, 1'b1);
        chk("mrst.full", fifo_full, 1'b0);
        check_model("mrst");
        #2 reset = 1'b0;
        step("post_rst", 1'b1, 4'hE);
        step("post_rst", 1'b0, 4'h0);
        chk("post_rst.leds", leds_out, 4'hE);
        for (int i = 0; i < 6; i++) step("post_rst", 1'b0, 4'h0);

        // HOLD_CYCLES=1: a new pattern every cycle, then the idle pattern.
        step1(1'b1, 4'h3, 4'h5, 1'b0, 1'b0);
        step1(1'b1, 4'h6, 4'h3, 1'b1, 1'b0);
        step1(1'b1, 4'h9, 4'h6, 1'b1, 1'b0);
        step1(1'b0, 4'h0, 4'h9, 1'b1, 1'b1);
        step1(1'b0, 4'h0, 4'h5, 1'b0, 1'b1);
        chk("h1.ovf", ovf1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
